// File: rtl/stream_merge2_arb_pkg.sv
// Shared definitions for the two-input stream merger and its matching
// demultiplexer: FSM state encodings and the source select tags.
// No ports (package).
package stream_merge2_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_B = 2'd1,
      ST_GRANT_C = 2'd2
   } state_e;

   // Tag carried with each output beat; the demultiplexer uses it as Select.
   localparam logic SEL_B = 1'b0;
   localparam logic SEL_C = 1'b1;

endpackage

// File: rtl/stream_merge2_arb_if.sv
// Valid/ready stream bundle used for the merger's inputs and output.
// Ports (signals):
//   data  : payload, DATA_W bits
//   sel   : source tag (meaningful on the merged output only)
//   valid : beat present, driven by the producer
//   ready : beat accepted when valid && ready, driven by the consumer
interface stream_merge2_arb_if #(
   parameter int DATA_W = 2
);
   logic [DATA_W-1:0] data;
   logic              sel;
   logic              valid;
   logic              ready;

   modport master (output data, output sel, output valid, input ready);
   modport slave  (input data, input sel, input valid, output ready);
endinterface

// File: rtl/stream_merge2_arb_reg_slice.sv
// Single registered output stage: holds one beat (data + tag) and reports
// whether it can take a new beat this cycle.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : an input handshake happens this cycle
//   data_i/sel_i : beat to capture on load_i
//   ready_i      : downstream consumer ready
//   slot_free_o  : register empty or being drained this cycle
//   valid_o, data_o, sel_o : registered output beat
module stream_reg_slice
   import stream_merge2_arb_pkg::*;
#(
   parameter int DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              sel_i,
   input  logic              ready_i,
   output logic              slot_free_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              sel_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              sel_q, sel_d;
   logic              slot_free;

   assign slot_free = !valid_q || ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      // Under backpressure everything holds; otherwise valid follows load.
      if (slot_free) begin
         valid_d = load_i;
         if (load_i) begin
            data_d = data_i;
            sel_d  = sel_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= SEL_B;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   assign slot_free_o = slot_free;
   assign valid_o     = valid_q;
   assign data_o      = data_q;
   assign sel_o       = sel_q;

endmodule

// File: rtl/stream_merge2_arb.sv
// Two-to-one stream merger with round-robin, burst-bounded arbitration.
// Each output beat is tagged with its source (SEL_B / SEL_C).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inB      : source B stream (slave)
//   inC      : source C stream (slave)
//   outA     : merged stream with select tag (master), registered
module stream_merge2_arb
   import stream_merge2_arb_pkg::*;
#(
   parameter int DATA_W    = 2,
   parameter int BURST_LEN = 4
) (
   input  logic         clk,
   input  logic         rst,
   stream_merge2_arb_if.slave  inB,
   stream_merge2_arb_if.slave  inC,
   stream_merge2_arb_if.master outA
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);

   state_e            state_q;
   logic [CNT_W-1:0]  count_q;
   logic              rr_q;

   logic              slot_free;
   logic              b_hs, c_hs;
   logic              grant_hs, grant_valid, other_valid;
   logic              last_beat;
   logic [DATA_W-1:0] load_data;
   logic              load_sel;

   // Readies are gated by rst so nothing is accepted while a stale grant
   // is still in the state register during reset.
   assign inB.ready = !rst && slot_free && (state_q == ST_GRANT_B);
   assign inC.ready = !rst && slot_free && (state_q == ST_GRANT_C);

   assign b_hs      = inB.valid && inB.ready;
   assign c_hs      = inC.valid && inC.ready;
   assign load_data = c_hs ? inC.data : inB.data;
   assign load_sel  = c_hs ? SEL_C : SEL_B;
   assign last_beat = (count_q == CNT_W'(BURST_LEN - 1));

   // View of the currently granted source and the one waiting.
   always_comb begin
      grant_hs    = 1'b0;
      grant_valid = 1'b0;
      other_valid = 1'b0;
      if (state_q == ST_GRANT_B) begin
         grant_hs    = b_hs;
         grant_valid = inB.valid;
         other_valid = inC.valid;
      end else if (state_q == ST_GRANT_C) begin
         grant_hs    = c_hs;
         grant_valid = inC.valid;
         other_valid = inB.valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         rr_q    <= SEL_B;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (inB.valid && inC.valid)
                  state_q <= (rr_q == SEL_C) ? ST_GRANT_C : ST_GRANT_B;
               else if (inB.valid)
                  state_q <= ST_GRANT_B;
               else if (inC.valid)
                  state_q <= ST_GRANT_C;
            end
            ST_GRANT_B, ST_GRANT_C: begin
               if ((grant_hs && last_beat) || (slot_free && !grant_valid)) begin
                  // Release: hand straight to the other source if it waits.
                  count_q <= '0;
                  rr_q    <= (state_q == ST_GRANT_B) ? SEL_C : SEL_B;
                  if (other_valid)
                     state_q <= (state_q == ST_GRANT_B) ? ST_GRANT_C : ST_GRANT_B;
                  else
                     state_q <= ST_IDLE;
               end else if (grant_hs) begin
                  count_q <= count_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   stream_reg_slice #(
      .DATA_W (DATA_W)
   ) u_slice (
      .clk         (clk),
      .rst         (rst),
      .load_i      (b_hs || c_hs),
      .data_i      (load_data),
      .sel_i       (load_sel),
      .ready_i     (outA.ready),
      .slot_free_o (slot_free),
      .valid_o     (outA.valid),
      .data_o      (outA.data),
      .sel_o       (outA.sel)
   );

endmodule

// File: tb/tb_stream_merge2_arb.sv
// Self-checking bench for stream_merge2_arb: directed scenarios plus a
// randomized phase, with per-source expected-beat queues as the reference.
module tb_stream_merge2_arb;

   localparam int DW = 2;
   localparam int BL = 4;

   logic clk;
   logic rst;

   stream_merge2_arb_if #(.DATA_W(DW)) inB ();
   stream_merge2_arb_if #(.DATA_W(DW)) inC ();
   stream_merge2_arb_if #(.DATA_W(DW)) outA ();

   stream_merge2_arb #(
      .DATA_W    (DW),
      .BURST_LEN (BL)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .inB  (inB),
      .inC  (inC),
      .outA (outA)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: every accepted input beat is queued per source; every output
   // beat must be the oldest outstanding beat of the source its tag names.
   logic [DW-1:0] qb[$];
   logic [DW-1:0] qc[$];
   logic          b_fire = 1'b0;
   logic          c_fire = 1'b0;
   logic          hold_pend = 1'b0;
   logic [DW-1:0] hold_data;
   logic          hold_sel;

   always @(negedge clk) begin
      b_fire = inB.valid && inB.ready;
      c_fire = inC.valid && inC.ready;
      if (rst) begin
         qb.delete();
         qc.delete();
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", outA.valid, 1);
            chk("hold_data", outA.data, hold_data);
            chk("hold_sel", outA.sel, hold_sel);
         end
         chk("ready_exclusive", inB.ready && inC.ready, 0);
         if (outA.valid && outA.ready) begin
            if (outA.sel == 1'b0) begin
               chk("b_beat_expected", qb.size() != 0, 1);
               if (qb.size() != 0) chk("b_order", outA.data, qb.pop_front());
            end else begin
               chk("c_beat_expected", qc.size() != 0, 1);
               if (qc.size() != 0) chk("c_order", outA.data, qc.pop_front());
            end
         end
         hold_pend = outA.valid && !outA.ready;
         hold_data = outA.data;
         hold_sel  = outA.sel;
         if (b_fire) qb.push_back(inB.data);
         if (c_fire) qc.push_back(inC.data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Well-behaved producers: a pending beat is held until accepted.
   task automatic drive(input logic want_b, input logic want_c);
      if (!inB.valid || b_fire) begin
         inB.valid = want_b;
         inB.data  = DW'($urandom);
      end
      if (!inC.valid || c_fire) begin
         inC.valid = want_c;
         inC.data  = DW'($urandom);
      end
      #1;
   endtask

   task automatic idle_reset();
      inB.valid = 1'b0;
      inC.valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [DW-1:0] sv_data;
   logic          sv_sel;
   bit            done;

   initial begin
      inB.sel = 1'b0;
      inC.sel = 1'b0;
      inB.data = 2'b01;
      inC.data = 2'b10;
      inB.valid = 1'b1;
      inC.valid = 1'b1;
      outA.ready = 1'b1;
      rst = 1'b1;

      // Reset held two cycles with both sources requesting
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_out_valid", outA.valid, 0);
         chk("rst_b_ready", inB.ready, 0);
         chk("rst_c_ready", inC.ready, 0);
      end
      inB.valid = 1'b0;
      inC.valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("post_rst_valid", outA.valid, 0);
      chk("post_rst_data", outA.data, 0);
      chk("post_rst_sel", outA.sel, 0);

      // Single source B: 01, 10, 11
      inB.valid = 1'b1;
      inB.data  = 2'b01;
      tick();
      chk("single_lat1_valid", outA.valid, 0);
      chk("single_b_ready", inB.ready, 1);
      tick();
      chk("single_lat2_valid", outA.valid, 1);
      chk("single_d0", outA.data, 2'b01);
      chk("single_s0", outA.sel, 0);
      inB.data = 2'b10;
      tick();
      chk("single_d1", outA.data, 2'b10);
      inB.data = 2'b11;
      tick();
      chk("single_d2", outA.data, 2'b11);
      chk("single_s2", outA.sel, 0);
      inB.valid = 1'b0;
      tick();
      chk("single_drain_valid", outA.valid, 0);

      // Contention: alternate full bursts, no bubble at hand-over
      idle_reset();
      drive(1, 1);
      tick();
      drive(1, 1);
      for (int i = 0; i < 4 * BL; i++) begin
         tick();
         chk("cont_valid", outA.valid, 1);
         chk("cont_sel", outA.sel, (i / BL) % 2);
         drive(1, 1);
      end

      // Backpressure mid-burst of B
      idle_reset();
      drive(1, 0);
      tick();
      drive(1, 0);
      tick();
      chk("bp_first_valid", outA.valid, 1);
      outA.ready = 1'b0;
      sv_data = outA.data;
      sv_sel  = outA.sel;
      drive(1, 0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_b_ready_low", inB.ready, 0);
         tick();
         chk("bp_data_stable", outA.data, sv_data);
         chk("bp_sel_stable", outA.sel, sv_sel);
         drive(1, 0);
      end
      outA.ready = 1'b1;
      for (int i = 0; i < BL - 1; i++) begin
         tick();
         chk("bp_rest_valid", outA.valid, 1);
         drive(1, 0);
      end
      chk("bp_release_ready", inB.ready, 0);
      tick();
      chk("bp_bubble", outA.valid, 0);

      // Early release of C, hand-over to B, C waits for B's release
      idle_reset();
      drive(0, 1);
      tick();
      drive(0, 1);
      tick();
      chk("early_c0_sel", outA.sel, 1);
      drive(0, 1);
      tick();
      chk("early_c1_sel", outA.sel, 1);
      drive(1, 0);
      tick();
      chk("early_switch_b", inB.ready, 1);
      chk("early_switch_c", inC.ready, 0);
      drive(1, 1);
      for (int i = 0; i < BL; i++) begin
         tick();
         chk("early_b_valid", outA.valid, 1);
         chk("early_b_sel", outA.sel, 0);
         chk("early_c_wait", inC.ready, (i == BL - 1) ? 1 : 0);
         drive(1, 1);
      end
      tick();
      chk("early_c_after_b", outA.sel, 1);

      // Reset in the middle of a burst
      idle_reset();
      drive(1, 1);
      tick();
      drive(1, 1);
      tick();
      drive(1, 1);
      tick();
      chk("midrst_pre_valid", outA.valid, 1);
      rst = 1'b1;
      tick();
      chk("midrst_valid", outA.valid, 0);
      chk("midrst_b_ready", inB.ready, 0);
      chk("midrst_c_ready", inC.ready, 0);
      rst = 1'b0;
      tick();
      chk("midrst_grant_b", inB.ready, 1);
      chk("midrst_no_c", inC.ready, 0);
      drive(1, 1);
      tick();
      chk("midrst_first_sel", outA.sel, 0);

      // Randomized traffic against the queue reference
      idle_reset();
      for (int i = 0; i < 400; i++) begin
         outA.ready = ($urandom_range(0, 3) != 0);
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
         tick();
      end
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         outA.ready = 1'b1;
         drive(0, 0);
         tick();
         done = !inB.valid && !inC.valid && !outA.valid &&
                qb.size() == 0 && qc.size() == 0;
      end
      chk("drain_b_empty", qb.size(), 0);
      chk("drain_c_empty", qc.size(), 0);
      chk("drain_out_idle", outA.valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
